// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC and issues sequential requests to a 1-cycle imem.
// Returned words are buffered with their PCs in a prefetch FIFO and presented to decode.
module fetch_unit #(
  parameter int unsigned          XLEN       = 32,
  parameter logic [XLEN-1:0]      RESET_PC   = 32'h0001_0000,
  parameter int unsigned          FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          fetch_en_i,
  input  logic                          redirect_i,
  input  logic [XLEN-1:0]               redirect_pc_i,
  output logic                          imem_req_o,
  output logic [XLEN-1:0]               imem_addr_o,
  input  logic                          imem_rvalid_i,
  input  logic [31:0]                   imem_rdata_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [31:0]                   instr_o,
  output logic [XLEN-1:0]               instr_pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             outstanding;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] rd_idx_next;

  logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];

  logic [31:0]      head_instr;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      head_instr_nxt;
  logic [XLEN-1:0]  head_pc_nxt;

  logic             req;
  logic             push;
  logic             pop;
  logic             full;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign wr_idx      = wr_ptr[PTR_W-1:0];
  assign rd_idx      = rd_ptr[PTR_W-1:0];
  assign rd_idx_next = rd_idx + PTR_W'(1);

  // An in-flight request already owns a slot; a same-cycle pop earns no credit.
  assign credit = {1'b0, count} + (CNT_W+1)'(outstanding);
  assign req    = fetch_en_i & ~redirect_i & (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign push   = imem_rvalid_i & outstanding & ~redirect_i;
  assign pop    = instr_valid_o & instr_ready_i & ~redirect_i;

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = (count != '0);
  assign instr_o       = head_instr;
  assign instr_pc_o    = head_pc;
  assign fifo_count_o  = count;

  // The head registers track whatever entry becomes the FIFO head and hold while empty.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_instr_nxt = head_instr;
    head_pc_nxt    = head_pc;
    if (!redirect_i) begin
      if ((count == '0) || (pop && (count == CNT_W'(1)))) begin
        if (push) begin
          head_instr_nxt = imem_rdata_i;
          head_pc_nxt    = req_pc;
        end
      end else if (pop) begin
        head_instr_nxt = instr_mem[rd_idx_next];
        head_pc_nxt    = pc_mem[rd_idx_next];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      head_instr  <= '0;
      head_pc     <= '0;
    end else begin
      head_instr <= head_instr_nxt;
      head_pc    <= head_pc_nxt;
      if (redirect_i) begin
        fetch_pc    <= redirect_pc_i & ~XLEN'(3);
        outstanding <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        outstanding <= req;
        if (req) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + CNT_W'(1);
        if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      end
    end
  end

  // NOTE: the storage array is not reset; an entry is only read once a push has written it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_idx]    <= req_pc;
      instr_mem[wr_idx] <= imem_rdata_i;
    end
  end

  push_never_full : assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && full));

endmodule
